// File: rtl/pc_stack_if.sv
// Command/status bundle for the program-counter block with its return-address stack.
// The master drives the commands and the slave (pc_stack) reports state.
interface pc_stack_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned SpW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in;
    logic             clear;
    logic             load;
    logic             inc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] out;
    logic [SpW-1:0]   sp;
    logic             empty;
    logic             full;
    logic             err;

    modport master (
        output in, clear, load, inc, call, ret,
        input  out, sp, empty, full, err
    );

    modport slave (
        input  in, clear, load, inc, call, ret,
        output out, sp, empty, full, err
    );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a return-address stack. Each edge performs exactly one command,
// with priority clear > call > ret > load > inc. Stack faults set a sticky err flag.
module pc_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    pc_stack_if.slave  bus
);
    localparam int unsigned SpW  = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

    logic [WIDTH-1:0] out_q, out_d;
    logic [SpW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic             push;
    logic             empty, full;
    logic [WIDTH-1:0] next_seq;
    logic [SpW-1:0]   sp_m1;
    logic [IdxW-1:0]  wr_idx, top_idx;

    assign empty    = (sp_q == '0);
    assign full     = (sp_q == SpW'(DEPTH));
    assign next_seq = out_q + StepW;
    assign sp_m1    = sp_q - SpW'(1);
    assign wr_idx   = sp_q[IdxW-1:0];
    assign top_idx  = sp_m1[IdxW-1:0];

    always_comb begin
        out_d = out_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (bus.clear) begin
            out_d = '0;
            sp_d  = '0;
            err_d = 1'b0;
        end else if (bus.call) begin
            if (!full) begin
                push  = 1'b1;
                out_d = bus.in;
                sp_d  = sp_q + SpW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.ret) begin
            if (!empty) begin
                out_d = stack_q[top_idx];
                sp_d  = sp_m1;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.load) begin
            out_d = bus.in;
        end else if (bus.inc) begin
            out_d = next_seq;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Entries at or above sp are never read, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            stack_q[wr_idx] <= next_seq;
        end
    end

    assign bus.out   = out_q;
    assign bus.sp    = sp_q;
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.err   = err_q;
endmodule
